// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the latency counter width.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Stores only know SB/SH/SW; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction
endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian byte-lane steering: store merge, load extract/extend and
// the alignment check. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wword,
  output logic [31:0] o_rword,
  output logic        o_misalign
);
  logic [7:0]  w_b;
  logic [15:0] w_h;

  always_comb begin
    w_b        = i_old[{i_lane, 3'b000} +: 8];
    w_h        = i_old[{i_lane[1], 4'b0000} +: 16];
    o_wword    = i_old;
    o_rword    = '0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B:  begin
        o_wword[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
        o_rword = {{24{w_b[7]}}, w_b};
      end
      F3_BU: o_rword = {24'd0, w_b};
      F3_H:  begin
        o_wword[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_rword    = {{16{w_h[15]}}, w_h};
        o_misalign = i_lane[0];
      end
      F3_HU: begin
        o_rword    = {16'd0, w_h};
        o_misalign = i_lane[0];
      end
      F3_W:  begin
        o_wword    = i_wdata;
        o_rword    = i_old;
        o_misalign = (i_lane != 2'b00);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/data_mem_responder.sv
// Load/store slave for the multicycle core: one request at a time,
// configurable latency, response held until the core accepts it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [2:0]         r_f3;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic [AW-1:0]      w_idx;
  logic [31:0]        w_old;
  logic [31:0]        w_wword;
  logic [31:0]        w_rword;
  logic               w_misalign;
  logic               w_oor;
  logic               w_err;
  logic               w_commit;

  assign w_idx    = r_addr[AW+1:2];
  assign w_old    = r_mem[w_idx];
  assign w_oor    = |(r_addr >> (AW + 2));
  assign w_err    = w_oor | w_misalign | ~f3_legal(r_we, r_f3);
  // The single array access happens on the edge that leaves WAIT for RESP.
  assign w_commit = (r_state == WAIT) && (r_cnt == '0);

  mem_lane_align u_align (
    .i_funct3   (r_f3),
    .i_lane     (r_addr[1:0]),
    .i_old      (w_old),
    .i_wdata    (r_wdata),
    .o_wword    (w_wword),
    .o_rword    (w_rword),
    .o_misalign (w_misalign)
  );

  // No reset on the array: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) r_mem[w_idx] <= w_wword;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_we        <= i_req_we;
          r_f3        <= i_req_funct3;
          r_addr      <= i_req_addr;
          r_wdata     <= i_req_wdata;
          r_cnt       <= CNT_W'(LATENCY - 1);
          r_req_ready <= 1'b0;
          r_state     <= WAIT;
        end
        // WAIT spans LATENCY cycles so rsp_valid rises LATENCY edges after acceptance.
        WAIT: if (r_cnt == '0) begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_err;
          r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_rword;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        RESP: if (i_rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut 0 has LATENCY=1, dut 1 has LATENCY=4; expected
// responses are queued at issue and popped by per-dut monitors.
module tb_data_mem_responder;
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        vld_i    [2];
  logic        we_i     [2];
  logic [2:0]  f3_i     [2];
  logic [31:0] addr_i   [2];
  logic [31:0] wd_i     [2];
  logic        rdy_i    [2];
  logic        req_rdy  [2];
  logic        rvld     [2];
  logic [31:0] rdata    [2];
  logic        rerr     [2];

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst[0]), .i_req_valid(vld_i[0]), .o_req_ready(req_rdy[0]),
    .i_req_we(we_i[0]), .i_req_funct3(f3_i[0]), .i_req_addr(addr_i[0]),
    .i_req_wdata(wd_i[0]), .o_rsp_valid(rvld[0]), .i_rsp_ready(rdy_i[0]),
    .o_rsp_rdata(rdata[0]), .o_rsp_err(rerr[0]));

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(rst[1]), .i_req_valid(vld_i[1]), .o_req_ready(req_rdy[1]),
    .i_req_we(we_i[1]), .i_req_funct3(f3_i[1]), .i_req_addr(addr_i[1]),
    .i_req_wdata(wd_i[1]), .o_rsp_valid(rvld[1]), .i_rsp_ready(rdy_i[1]),
    .o_rsp_rdata(rdata[1]), .o_rsp_err(rerr[1]));

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst[0] && rvld[0] && rdy_i[0]) begin
      if (q0.size() == 0) chk(1'b0, "l1_unexpected_rsp", rdata[0], 32'd0);
      else begin
        e = q0.pop_front();
        chk(rdata[0] === e.rdata, "l1_rdata", rdata[0], e.rdata);
        chk(rerr[0] === e.err, "l1_err", {31'd0, rerr[0]}, {31'd0, e.err});
      end
    end
    if (!rst[1] && rvld[1] && rdy_i[1]) begin
      if (q1.size() == 0) chk(1'b0, "l4_unexpected_rsp", rdata[1], 32'd0);
      else begin
        e = q1.pop_front();
        chk(rdata[1] === e.rdata, "l4_rdata", rdata[1], e.rdata);
        chk(rerr[1] === e.err, "l4_err", {31'd0, rerr[1]}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input int s, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    chk(req_rdy[s] === 1'b1, "req_ready_idle", {31'd0, req_rdy[s]}, 32'd1);
    we_i[s] = we; f3_i[s] = f3; addr_i[s] = a; wd_i[s] = wd; vld_i[s] = 1'b1;
    @(posedge clk); #1;
    vld_i[s] = 1'b0;
  endtask

  // One full access; hold = cycles rsp_ready is kept low once the response is up.
  task automatic access(input int s, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ex_d, input logic ex_e,
                        input int lat, input int hold);
    exp_t e;
    int k;
    bit got;
    e.rdata = ex_d; e.err = ex_e;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    rdy_i[s] = (hold == 0);
    drive(s, we, f3, a, wd);
    k = 0; got = 0;
    while (k < 40 && !got) begin
      @(negedge clk); k++;
      if (rvld[s] === 1'b1) got = 1;
    end
    chk(got && (k == lat + 1), "rsp_latency", 32'(k - 1), 32'(lat));
    if (!got) begin
      rdy_i[s] = 1'b1;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk(rvld[s] === 1'b1, "hold_valid", {31'd0, rvld[s]}, 32'd1);
      chk(rdata[s] === ex_d, "hold_rdata", rdata[s], ex_d);
      chk(rerr[s] === ex_e, "hold_err", {31'd0, rerr[s]}, {31'd0, ex_e});
      chk(req_rdy[s] === 1'b0, "hold_req_ready", {31'd0, req_rdy[s]}, 32'd0);
      @(posedge clk); #1;
    end
    rdy_i[s] = 1'b1;
    @(posedge clk); #1;
    chk(req_rdy[s] === 1'b1 && rvld[s] === 1'b0, "after_handshake",
        {30'd0, req_rdy[s], rvld[s]}, 32'h2);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 0; vld_i[i] = 0; we_i[i] = 0; f3_i[i] = 0;
      addr_i[i] = 0; wd_i[i] = 0; rdy_i[i] = 1;
    end
    #2;
    rst[0] = 1; rst[1] = 1;
    #1;
    for (int i = 0; i < 2; i++)
      chk(req_rdy[i] === 1'b1 && rvld[i] === 1'b0 && rdata[i] === 32'd0 && rerr[i] === 1'b0,
          "reset_state", {req_rdy[i], rvld[i], rerr[i], rdata[i][28:0]}, 32'h80000000);
    repeat (2) @(posedge clk);
    #1; rst[0] = 0; rst[1] = 0;

    // LATENCY = 1: word, byte, half accesses
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 0);
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 0);
    access(0, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1, 0);
    access(0, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 1, 0);
    access(0, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1, 0);
    access(0, 0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0, 1, 0);
    access(0, 1, 3'b000, 32'h11, 32'hAAAAAA55, 32'h0,        0, 1, 0);
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0, 1, 0);
    access(0, 1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0,        0, 1, 0);
    access(0, 0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 0, 1, 0);
    access(0, 0, 3'b000, 32'h12, 32'h0,        32'h00000034, 0, 1, 0);
    access(0, 0, 3'b001, 32'h10, 32'h0,        32'h000055EF, 0, 1, 0);
    // errors: no write, zero data
    access(0, 1, 3'b001, 32'h11,   32'hFFFFFFFF, 32'h0, 1, 1, 0);
    access(0, 1, 3'b010, 32'h1000, 32'h0,        32'h0, 1, 1, 0);
    access(0, 0, 3'b011, 32'h10,   32'h0,        32'h0, 1, 1, 0);
    access(0, 1, 3'b100, 32'h10,   32'h0,        32'h0, 1, 1, 0);
    access(0, 0, 3'b010, 32'h12,   32'h0,        32'h0, 1, 1, 0);
    access(0, 0, 3'b010, 32'h10,   32'h0,        32'h123455EF, 0, 1, 0);
    // last word of the array
    access(0, 1, 3'b010, 32'hFFC,  32'hA5A5A5A5, 32'h0,        0, 1, 0);
    access(0, 0, 3'b010, 32'hFFC,  32'h0,        32'hA5A5A5A5, 0, 1, 0);

    // LATENCY = 4 with backpressure
    access(1, 1, 3'b010, 32'h40, 32'h80000001, 32'h0,        0, 4, 0);
    access(1, 0, 3'b010, 32'h40, 32'h0,        32'h80000001, 0, 4, 3);
    access(1, 0, 3'b001, 32'h41, 32'h0,        32'h0,        1, 4, 2);

    // reset in WAIT drops the pending store
    access(1, 1, 3'b010, 32'h20, 32'h11111111, 32'h0,        0, 4, 0);
    access(1, 0, 3'b010, 32'h20, 32'h0,        32'h11111111, 0, 4, 0);
    drive(1, 1, 3'b010, 32'h20, 32'hCAFEBABE);
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 1;
    #1;
    chk(req_rdy[1] === 1'b1 && rvld[1] === 1'b0 && rerr[1] === 1'b0,
        "reset_in_wait_ctl", {29'd0, req_rdy[1], rvld[1], rerr[1]}, 32'h4);
    chk(rdata[1] === 32'd0, "reset_in_wait_rdata", rdata[1], 32'd0);
    repeat (2) @(posedge clk);
    #1; rst[1] = 0;
    access(1, 0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0, 4, 0);

    repeat (2) @(posedge clk);
    chk(q0.size() == 0, "l1_queue_drained", 32'(q0.size()), 32'd0);
    chk(q1.size() == 0, "l4_queue_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
